// File: rtl/pc_pkg.sv
// Shared defaults and next-PC select encoding for the program-counter unit.
package pc_pkg;

    localparam int unsigned PC_W_DEF = 32;
    localparam int unsigned INC_DEF  = 4;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_BR,
        SEL_JMP,
        SEL_PEND,
        SEL_HOLD
    } pc_sel_e;

endpackage

// File: rtl/pc_adder_n.sv
// Parametrised N-bit adder with carry-in and carry-out.
module pc_adder_n #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    logic [N:0] w_full;

    always_comb begin
        w_full = {1'b0, i_a} + {1'b0, i_b} + {{N{1'b0}}, i_cin};
    end

    assign o_sum  = w_full[N-1:0];
    assign o_cout = w_full[N];

endmodule

// File: rtl/pc_unit.sv
// Registered program counter with branch/jump redirect and stall buffering.
// Optional target-alignment check enabled by defining PC_ALIGN_CHK_EN.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned PC_W     = PC_W_DEF,
    parameter int unsigned INC      = INC_DEF,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned BR_OFF_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                br_taken,
    input  logic [BR_OFF_W-1:0] br_off,
    input  logic                jmp_en,
    input  logic [PC_W-1:0]     jmp_target,
    output logic [PC_W-1:0]     pc,
    output logic [PC_W-1:0]     pc_plus,
    output logic                cout,
    output logic                redirect_pend,
    output logic                misalign
);

    logic [PC_W-1:0] r_pc;
    logic            r_pend_valid;
    logic [PC_W-1:0] r_pend_target;

    logic [PC_W-1:0] w_pc_plus;
    logic            w_cout;
    logic [PC_W-3:0] w_off_ext;
    logic [PC_W-1:0] w_off_sh;
    logic [PC_W-1:0] w_br_tgt;
    logic            w_redir;
    logic [PC_W-1:0] w_tgt;
    logic            w_bad;
    logic            w_redir_ok;
    logic [PC_W-1:0] w_pc_next;
    pc_sel_e         w_sel;

    pc_adder_n #(.N(PC_W)) u_inc_add (
        .i_a    (r_pc),
        .i_b    (PC_W'(INC)),
        .i_cin  (1'b0),
        .o_sum  (w_pc_plus),
        .o_cout (w_cout)
    );

    // Word offset is sign-extended then scaled to bytes; result wraps modulo 2^PC_W.
    assign w_off_ext = (PC_W-2)'($signed(br_off));
    assign w_off_sh  = {w_off_ext, 2'b00};

    pc_adder_n #(.N(PC_W)) u_br_add (
        .i_a    (w_pc_plus),
        .i_b    (w_off_sh),
        .i_cin  (1'b0),
        .o_sum  (w_br_tgt),
        .o_cout ()
    );

    assign w_redir = jmp_en | br_taken;
    assign w_tgt   = jmp_en ? jmp_target : w_br_tgt;

`ifdef PC_ALIGN_CHK_EN
    assign w_bad = w_redir & (|w_tgt[1:0]);
`else
    assign w_bad = 1'b0;
`endif
    assign w_redir_ok = w_redir & ~w_bad;

    // Next-PC selection: stall holds, live redirect beats a buffered one.
    always_comb begin
        w_sel = SEL_SEQ;
        if (stall)
            w_sel = SEL_HOLD;
        else if (w_redir_ok)
            w_sel = jmp_en ? SEL_JMP : SEL_BR;
        else if (r_pend_valid)
            w_sel = SEL_PEND;
    end

    always_comb begin
        w_pc_next = w_pc_plus;
        unique case (w_sel)
            SEL_SEQ:  w_pc_next = w_pc_plus;
            SEL_BR:   w_pc_next = w_br_tgt;
            SEL_JMP:  w_pc_next = jmp_target;
            SEL_PEND: w_pc_next = r_pend_target;
            SEL_HOLD: w_pc_next = r_pc;
            default:  w_pc_next = w_pc_plus;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= PC_W'(RESET_PC);
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else begin
            r_pc <= w_pc_next;
            if (stall && w_redir_ok) begin
                r_pend_target <= w_tgt;
                r_pend_valid  <= 1'b1;
            end else if (!stall) begin
                r_pend_valid  <= 1'b0;
            end
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset)
            r_misalign <= 1'b0;
        else
            r_misalign <= w_bad;
    end

    assign misalign = r_misalign;
`else
    assign misalign = 1'b0;
`endif

    assign pc            = r_pc;
    assign pc_plus       = w_pc_plus;
    assign cout          = w_cout;
    assign redirect_pend = r_pend_valid;

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (32-bit instance plus an 8-bit wrap instance).
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [15:0] br_off;
    logic        jmp_en;
    logic [31:0] jmp_target;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        cout;
    logic        redirect_pend;
    logic        misalign;

    logic        s_stall;
    logic [5:0]  s_br_off;
    logic [7:0]  s_jmp_target;
    logic [7:0]  s_pc;
    logic [7:0]  s_pc_plus;
    logic        s_cout;
    logic        s_redirect_pend;
    logic        s_misalign;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .PC_W     (32),
        .INC      (4),
        .RESET_PC (32'h0040_0000),
        .BR_OFF_W (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_off        (br_off),
        .jmp_en        (jmp_en),
        .jmp_target    (jmp_target),
        .pc            (pc),
        .pc_plus       (pc_plus),
        .cout          (cout),
        .redirect_pend (redirect_pend),
        .misalign      (misalign)
    );

    pc_unit #(
        .PC_W     (8),
        .INC      (4),
        .RESET_PC (8'hFC),
        .BR_OFF_W (6)
    ) dut_s (
        .clk           (clk),
        .reset         (reset),
        .stall         (s_stall),
        .br_taken      (1'b0),
        .br_off        (s_br_off),
        .jmp_en        (1'b0),
        .jmp_target    (s_jmp_target),
        .pc            (s_pc),
        .pc_plus       (s_pc_plus),
        .cout          (s_cout),
        .redirect_pend (s_redirect_pend),
        .misalign      (s_misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; br_taken = 1'b0; br_off = '0;
        jmp_en = 1'b0; jmp_target = '0;
        s_stall = 1'b1; s_br_off = '0; s_jmp_target = '0;
        tick(); tick();
        check("rst_pc", pc, 32'h0040_0000);
        check("rst_pend", {31'd0, redirect_pend}, 32'd0);
        check("rst_mis", {31'd0, misalign}, 32'd0);
        reset = 1'b0;
        check("rst_pc_plus", pc_plus, 32'h0040_0004);

        // 8-bit wrap: held at 0xFC, then released for one cycle
        check("w8_pc", {24'd0, s_pc}, 32'hFC);
        check("w8_cout", {31'd0, s_cout}, 32'd1);
        check("w8_plus", {24'd0, s_pc_plus}, 32'h00);
        check("w8_pend", {31'd0, s_redirect_pend}, 32'd0);
        s_stall = 1'b0;
        tick();
        s_stall = 1'b1;
        check("w8_wrap", {24'd0, s_pc}, 32'h00);
        check("w8_cout0", {31'd0, s_cout}, 32'd0);
        check("w8_mis", {31'd0, s_misalign}, 32'd0);

        check("seq0", pc, 32'h0040_0004);
        tick(); check("seq1", pc, 32'h0040_0008);
        tick(); check("seq2", pc, 32'h0040_000C);
        check("seq_pend", {31'd0, redirect_pend}, 32'd0);

        // Branch backward from 0x100
        jmp_en = 1'b1; jmp_target = 32'h100; tick(); jmp_en = 1'b0;
        check("jmp100", pc, 32'h100);
        br_taken = 1'b1; br_off = 16'hFFFE;
        check("br_plus", pc_plus, 32'h104);
        tick(); br_taken = 1'b0;
        check("br_back", pc, 32'h0FC);

        // Jump beats branch
        jmp_en = 1'b1; jmp_target = 32'h100; tick();
        br_taken = 1'b1; br_off = 16'hFFFE; jmp_target = 32'h800; tick();
        jmp_en = 1'b0; br_taken = 1'b0;
        check("jmp_wins", pc, 32'h800);

        // Forward branch: 0x804 + 3*4
        br_taken = 1'b1; br_off = 16'd3; tick(); br_taken = 1'b0;
        check("br_fwd", pc, 32'h810);

        // Stall with two redirects; newest (branch to 0x300) wins
        jmp_en = 1'b1; jmp_target = 32'h200; tick(); jmp_en = 1'b0;
        check("at200", pc, 32'h200);
        stall = 1'b1; tick();
        check("st1_pc", pc, 32'h200);
        check("st1_pend", {31'd0, redirect_pend}, 32'd0);
        jmp_en = 1'b1; jmp_target = 32'h400; tick(); jmp_en = 1'b0;
        check("st2_pc", pc, 32'h200);
        check("st2_pend", {31'd0, redirect_pend}, 32'd1);
        br_taken = 1'b1; br_off = 16'd63; tick(); br_taken = 1'b0;
        check("st3_pc", pc, 32'h200);
        check("st3_pend", {31'd0, redirect_pend}, 32'd1);
        stall = 1'b0; tick();
        check("resume_pc", pc, 32'h300);
        check("resume_pend", {31'd0, redirect_pend}, 32'd0);
        tick(); check("resume_seq", pc, 32'h304);

        // Live redirect beats the buffered one
        stall = 1'b1; jmp_en = 1'b1; jmp_target = 32'h600; tick();
        check("buf_pend", {31'd0, redirect_pend}, 32'd1);
        stall = 1'b0; jmp_target = 32'h700; tick(); jmp_en = 1'b0;
        check("live_pc", pc, 32'h700);
        check("live_pend", {31'd0, redirect_pend}, 32'd0);
        tick(); check("live_seq", pc, 32'h704);

        // Reset while stalled with a pending redirect discards it
        stall = 1'b1; jmp_en = 1'b1; jmp_target = 32'h500; tick(); jmp_en = 1'b0;
        check("pre_rst_pend", {31'd0, redirect_pend}, 32'd1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_pc", pc, 32'h0040_0000);
        check("mid_rst_pend", {31'd0, redirect_pend}, 32'd0);
        stall = 1'b0; tick();
        check("post_rst_pc", pc, 32'h0040_0004);

        // Misaligned jump target
        jmp_en = 1'b1; jmp_target = 32'h40; tick();
        check("at40", pc, 32'h40);
        check("at40_mis", {31'd0, misalign}, 32'd0);
        jmp_target = 32'h402; tick(); jmp_en = 1'b0;
`ifdef PC_ALIGN_CHK_EN
        check("mis_pc", pc, 32'h44);
        check("mis_flag", {31'd0, misalign}, 32'd1);
        tick();
        check("mis_pc2", pc, 32'h48);
        check("mis_flag2", {31'd0, misalign}, 32'd0);
`else
        check("mis_pc", pc, 32'h402);
        check("mis_flag", {31'd0, misalign}, 32'd0);
        tick();
        check("mis_pc2", pc, 32'h406);
        check("mis_flag2", {31'd0, misalign}, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
